calibration_sequencer: RTL and testbench

Sequences the room-calibration flow ahead of the convolution path. On request it triggers DC-offset calibration, waits a settle interval, then triggers impulse-response recording and enables convolution once recording completes. It sits between the user buttons and the offset calculator, impulse recorder and convolver, and produces the mute and enable strobes for the output mux. It runs entirely on the audio clock and counts time in audio-sample strobes.

---
 rtl/calibration_sequencer.sv | 172 +++++++++++++++++
 tb/tb_calibration_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/calibration_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calibration_sequencer
// Purpose  : Sequences room calibration ahead of the convolution path.
//            A start request triggers DC-offset calibration, waits a settle
//            interval, triggers impulse-response recording and enables the
//            convolver once recording completes. Time is counted in audio
//            sample strobes on a shared saturating 16-bit counter.
// Ports    : audio_clk           - audio clock
//            rst_in              - asynchronous active-high reset
//            audio_trigger       - one-cycle sample strobe
//            start_in / abort_in - one-cycle user requests
//            offset_done_in      - one-cycle pulse from offset calculator
//            ir_done_in          - level, high once the IR is stored
//            offset_trigger_out  - one-cycle pulse starting offset calc
//            impulse_trigger_out - one-cycle pulse starting IR recording
//            mute_out            - mutes pass-through audio while busy
//            conv_enable_out     - convolver output enable (RUN)
//            busy_out            - calibration in progress
//            error_out           - sticky timeout flag
//            state_out           - current state encoding
// Config   : CAL_SEQ_AUTOSTART_EN - when defined, one calibration is started
//            automatically on the first clock after reset release.
// Revision : 1.0 - initial release
// ============================================================================
module calibration_sequencer #(
  parameter int unsigned SETTLE_SAMPLES = 2400,
  parameter int unsigned OFFSET_TIMEOUT = 48000,
  parameter int unsigned IR_TIMEOUT     = 48000
) (
  input  logic       audio_clk,
  input  logic       rst_in,
  input  logic       audio_trigger,
  input  logic       start_in,
  input  logic       abort_in,
  input  logic       offset_done_in,
  input  logic       ir_done_in,
  output logic       offset_trigger_out,
  output logic       impulse_trigger_out,
  output logic       mute_out,
  output logic       conv_enable_out,
  output logic       busy_out,
  output logic       error_out,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OFFSET = 3'd1,
    S_SETTLE = 3'd2,
    S_RECORD = 3'd3,
    S_RUN    = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [15:0] SETTLE_LIM = 16'(SETTLE_SAMPLES);
  localparam logic [15:0] OFFSET_LIM = 16'(OFFSET_TIMEOUT);
  localparam logic [15:0] IR_LIM     = 16'(IR_TIMEOUT);

  state_t      state;
  state_t      next_state;
  logic [15:0] count;
  logic [15:0] count_next;
  logic        ir_prev;
  logic        ir_rise;
  logic        start_eff;
  logic        offset_pulse;
  logic        impulse_pulse;

`ifdef CAL_SEQ_AUTOSTART_EN
  // Armed by reset, consumed on the first clock after release.
  logic auto_pend;

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      auto_pend <= 1'b1;
    end else begin
      auto_pend <= 1'b0;
    end
  end

  assign start_eff = start_in | auto_pend;
`else
  assign start_eff = start_in;
`endif

  assign ir_rise = ir_done_in & ~ir_prev;

  // Count value as it will be after this edge; limits are compared against it
  // so a state exits on the very edge that registers the Nth sample strobe.
  assign count_next = (audio_trigger && (count != 16'hFFFF)) ? count + 16'd1 : count;

  always_comb begin
    next_state    = state;
    offset_pulse  = 1'b0;
    impulse_pulse = 1'b0;
    if (abort_in) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_eff) begin
            next_state   = S_OFFSET;
            offset_pulse = 1'b1;
          end
        end
        S_OFFSET: begin
          if (offset_done_in) begin
            next_state = S_SETTLE;
          end else if (count_next >= OFFSET_LIM) begin
            next_state = S_FAULT;
          end
        end
        S_SETTLE: begin
          if (count_next >= SETTLE_LIM) begin
            next_state    = S_RECORD;
            impulse_pulse = 1'b1;
          end
        end
        S_RECORD: begin
          if (ir_rise) begin
            next_state = S_RUN;
          end else if (count_next >= IR_LIM) begin
            next_state = S_FAULT;
          end
        end
        S_RUN, S_FAULT: begin
          if (start_eff) begin
            next_state   = S_OFFSET;
            offset_pulse = 1'b1;
          end
        end
        default: begin
          next_state = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from next_state so they appear in the first cycle of
  // the new state, registered alongside it.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state               <= S_IDLE;
      count               <= 16'd0;
      ir_prev             <= 1'b0;
      offset_trigger_out  <= 1'b0;
      impulse_trigger_out <= 1'b0;
      mute_out            <= 1'b0;
      conv_enable_out     <= 1'b0;
      busy_out            <= 1'b0;
      error_out           <= 1'b0;
      state_out           <= 3'd0;
    end else begin
      state               <= next_state;
      count               <= (next_state != state) ? 16'd0 : count_next;
      ir_prev             <= ir_done_in;
      offset_trigger_out  <= offset_pulse;
      impulse_trigger_out <= impulse_pulse;
      busy_out            <= (next_state == S_OFFSET) || (next_state == S_SETTLE) ||
                             (next_state == S_RECORD);
      mute_out            <= (next_state == S_OFFSET) || (next_state == S_SETTLE) ||
                             (next_state == S_RECORD);
      conv_enable_out     <= (next_state == S_RUN);
      // FAULT is only left via start or abort, both of which clear the flag.
      error_out           <= (next_state == S_FAULT);
      state_out           <= next_state;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calibration_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calibration_sequencer
// Purpose  : Directed, table-driven bench for calibration_sequencer with
//            SETTLE_SAMPLES=4, OFFSET_TIMEOUT=8, IR_TIMEOUT=10 and a sample
//            strobe every 4 clocks, plus hand-written reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calibration_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       odone = 1'b0;
  logic       ir = 1'b0;
  logic       ot, it, mu, cv, bz, er;
  logic [2:0] st;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic       s, a, o, i, t;
    int         cyc;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  calibration_sequencer #(
    .SETTLE_SAMPLES(4),
    .OFFSET_TIMEOUT(8),
    .IR_TIMEOUT    (10)
  ) dut (
    .audio_clk          (clk),
    .rst_in             (rst),
    .audio_trigger      (trig),
    .start_in           (start),
    .abort_in           (abort),
    .offset_done_in     (odone),
    .ir_done_in         (ir),
    .offset_trigger_out (ot),
    .impulse_trigger_out(it),
    .mute_out           (mu),
    .conv_enable_out    (cv),
    .busy_out           (bz),
    .error_out          (er),
    .state_out          (st)
  );

  always #5 clk = ~clk;

  // Expected {state, offset_trig, impulse_trig, mute, conv, busy, error}.
  function automatic logic [8:0] expv(input logic [2:0] s, input logic o, input logic i);
    logic b;
    b = (s == 3'd1) || (s == 3'd2) || (s == 3'd3);
    return {s, o, i, b, (s == 3'd4), b, (s == 3'd5)};
  endfunction

  function automatic logic [8:0] got();
    return {st, ot, it, mu, cv, bz, er};
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    nvec++;
    if (got() !== exp) begin
      nerr++;
      $display("FAIL %s: got st/ot/it/mu/cv/bz/er=%b required %b", name, got(), exp);
    end
  endtask

  task automatic add(input logic s, a, o, i, t, input int cyc,
                     input logic [2:0] es, input logic eo, ei);
    vec_t v;
    v.s = s; v.a = a; v.o = o; v.i = i; v.t = t; v.cyc = cyc;
    v.exp = expv(es, eo, ei);
    tbl.push_back(v);
  endtask

  // n quiet sample periods (3 idle clocks then a strobe) with no transition.
  task automatic samp(input int n, input logic i, input logic [2:0] es);
    for (int k = 0; k < n; k++) begin
      add(0, 0, 0, i, 0, 3, es, 0, 0);
      add(0, 0, 0, i, 1, 1, es, 0, 0);
    end
  endtask

  task automatic drive(input logic s, a, o, i, t);
    start = s; abort = a; odone = o; ir = i; trig = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- nominal flow ----
    add(0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 1, 0);
    samp(3, 0, 1);
    add(0, 0, 1, 0, 0, 1, 2, 0, 0);
    samp(3, 0, 2);
    add(0, 0, 0, 0, 0, 3, 2, 0, 0);
    add(0, 0, 0, 0, 1, 1, 3, 0, 1);     // 4th settle sample -> RECORD
    add(0, 0, 0, 0, 0, 1, 3, 0, 0);
    samp(5, 0, 3);
    add(0, 0, 0, 1, 0, 1, 4, 0, 0);     // IR edge -> RUN
    add(0, 0, 0, 1, 0, 2, 4, 0, 0);
    // ---- offset timeout, then recovery ----
    add(0, 0, 0, 0, 0, 1, 4, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 1, 0);
    samp(7, 0, 1);
    add(0, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 5, 0, 0);     // 8th sample -> FAULT
    add(0, 0, 0, 0, 0, 2, 5, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 1, 0);     // restart clears error
    // ---- offset_done together with the 8th sample ----
    samp(7, 0, 1);
    add(0, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 1, 0, 1, 1, 2, 0, 0);
    samp(3, 0, 2);
    add(0, 0, 0, 0, 0, 3, 2, 0, 0);
    add(0, 0, 0, 0, 1, 1, 3, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0);     // abort in RECORD
    // ---- stale IR level ----
    add(0, 0, 0, 1, 0, 2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 1, 1, 0);
    samp(3, 1, 1);
    add(0, 0, 1, 1, 0, 1, 2, 0, 0);
    samp(3, 1, 2);
    add(0, 0, 0, 1, 0, 3, 2, 0, 0);
    add(0, 0, 0, 1, 1, 1, 3, 0, 1);
    samp(2, 1, 3);                      // level held: no exit
    add(0, 0, 0, 0, 0, 1, 3, 0, 0);
    add(0, 0, 0, 1, 0, 1, 4, 0, 0);     // fresh edge -> RUN
    // ---- IR timeout with a stale level ----
    add(1, 0, 0, 1, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 1, 2, 0, 0);
    samp(3, 1, 2);
    add(0, 0, 0, 1, 0, 3, 2, 0, 0);
    add(0, 0, 0, 1, 1, 1, 3, 0, 1);
    samp(9, 1, 3);
    add(0, 0, 0, 1, 0, 3, 3, 0, 0);
    add(0, 0, 0, 1, 1, 1, 5, 0, 0);     // 10th sample -> FAULT
    add(0, 1, 0, 0, 0, 1, 0, 0, 0);     // abort clears error
    add(1, 1, 0, 0, 0, 1, 0, 0, 0);     // abort beats start in IDLE
    add(0, 0, 0, 0, 0, 2, 0, 0, 0);

    // ---- reset state ----
    @(posedge clk); #1;
    check("reset_state", expv(0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef CAL_SEQ_AUTOSTART_EN
    drive(0, 0, 0, 0, 0);
    check("autostart_first", expv(1, 1, 0));
    drive(0, 0, 0, 0, 0);
    check("autostart_once", expv(1, 0, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int k = 0; k < 10; k++) begin
        drive(0, 0, 0, 0, 0);
        if (ot) pulses++;
        if (k == 0) check("autostart_rearm", expv(1, 1, 0));
      end
      nvec++;
      if (pulses != 1) begin
        nerr++;
        $display("FAIL autostart_count: got %0d pulses required 1", pulses);
      end
    end
    drive(0, 1, 0, 0, 0);
    check("autostart_abort", expv(0, 0, 0));
`else
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0);
      check("idle_after_reset", expv(0, 0, 0));
    end
`endif

    // ---- table ----
    for (int r = 0; r < tbl.size(); r++) begin
      for (int c = 0; c < tbl[r].cyc; c++) begin
        drive(tbl[r].s, tbl[r].a, tbl[r].o, tbl[r].i, tbl[r].t);
        check($sformatf("row%0d", r), tbl[r].exp);
      end
    end

    // ---- asynchronous reset while in SETTLE ----
    drive(1, 0, 0, 0, 0);
    check("rst_seq_start", expv(1, 1, 0));
    drive(0, 0, 1, 0, 0);
    check("rst_seq_settle", expv(2, 0, 0));
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    check("rst_seq_pre", expv(2, 0, 0));
    rst = 1'b1;
    #1;
    check("rst_async", expv(0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      drive(0, 0, 0, 0, (k % 4) == 3);
`ifdef CAL_SEQ_AUTOSTART_EN
      if (k == 0) check("rst_release", expv(1, 1, 0));
      else        check("rst_release", expv(1, 0, 0));
`else
      check("rst_release", expv(0, 0, 0));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
